mem_bus_ctrl: RTL and testbench

Two-master memory bus controller sitting between the CPU core (master 0), a second bus master such as DMA or debug (master 1), and the shared 16-bit memory bus. It arbitrates round-robin between the masters and decodes address[15:14] into one-hot chip selects CS0..CS3 for the four 16 KiB regions. It holds each access for a per-region number of wait states and returns a one-cycle acknowledge with registered read data.

---
 rtl/mem_bus_ctrl.sv | 155 +++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// Two-master round-robin memory bus controller with one-hot
// region chip selects and per-region wait states.
module mem_bus_ctrl #(
  parameter logic [3:0] WS0 = 4'd0,
  parameter logic [3:0] WS1 = 4'd1,
  parameter logic [3:0] WS2 = 4'd2,
  parameter logic [3:0] WS3 = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m0_wdata,
  output logic        m0_ack,
  output logic [15:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m1_wdata,
  output logic        m1_ack,
  output logic [15:0] m1_rdata,
  output logic [15:0] bus_addr,
  output logic [15:0] bus_wdata,
  output logic        bus_we,
  output logic        bus_re,
  output logic        CS0,
  output logic        CS1,
  output logic        CS2,
  output logic        CS3,
  input  logic [15:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ptr_q, ptr_d;
  logic        gnt_q, gnt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        we_q, we_d;
  logic [15:0] rd0_q, rd0_d;
  logic [15:0] rd1_q, rd1_d;
  logic        sel;
  logic [3:0]  cs;

  function automatic logic [3:0] ws_of(input logic [1:0] r);
    logic [3:0] w;
    unique case (r)
      2'd0:    w = WS0;
      2'd1:    w = WS1;
      2'd2:    w = WS2;
      default: w = WS3;
    endcase
    return w;
  endfunction

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    sel     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          // On a tie the master not granted last wins.
          sel     = (m0_req && m1_req) ? ~ptr_q : m1_req;
          gnt_d   = sel;
          addr_d  = sel ? m1_addr  : m0_addr;
          wdata_d = sel ? m1_wdata : m0_wdata;
          we_d    = sel ? m1_we    : m0_we;
          cnt_d   = ws_of(addr_d[15:14]);
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (!we_q) begin
            if (gnt_q) rd1_d = bus_rdata;
            else       rd0_d = bus_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        ptr_d   = gnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      we_q    <= 1'b0;
      rd0_q   <= 16'h0000;
      rd1_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

  always_comb begin
    cs = 4'b0000;
    if (state_q == ACCESS) begin
      unique case (addr_q[15:14])
        2'd0:    cs = 4'b0001;
        2'd1:    cs = 4'b0010;
        2'd2:    cs = 4'b0100;
        default: cs = 4'b1000;
      endcase
    end
  end

  assign CS0       = cs[0];
  assign CS1       = cs[1];
  assign CS2       = cs[2];
  assign CS3       = cs[3];
  assign bus_we    = (state_q == ACCESS) &&  we_q;
  assign bus_re    = (state_q == ACCESS) && !we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign m0_ack    = (state_q == DONE) && !gnt_q;
  assign m1_ack    = (state_q == DONE) &&  gnt_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: directed vector table, corner sequences
// and a randomized run against a transaction-timing model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack, m1_ack;
  logic [15:0] m0_rdata, m1_rdata;
  logic [15:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_we, bus_re;
  logic        CS0, CS1, CS2, CS3;
  logic [3:0]  cs_vec;
  logic        fixed_en;
  logic [15:0] fixed_rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re),
    .CS0(CS0), .CS1(CS1), .CS2(CS2), .CS3(CS3),
    .bus_rdata(bus_rdata)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], ~a[15:8]} ^ 16'h1357;
  endfunction

  function automatic int ws_of(input logic [1:0] r);
    int w;
    case (r)
      2'd0:    w = 0;
      2'd1:    w = 1;
      2'd2:    w = 2;
      default: w = 3;
    endcase
    return w;
  endfunction

  assign cs_vec    = {CS3, CS2, CS1, CS0};
  assign bus_rdata = fixed_en ? fixed_rdata : mem_f(bus_addr);

  typedef struct {
    logic        m;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic [3:0]  cs;
    int          width;
  } vec_t;

  vec_t        tbl[6];
  logic [15:0] last_rd[2];
  logic [3:0]  tie_cs[9];
  logic [1:0]  tie_ack[9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h",
               nm, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_m(input int m, input logic r, input logic we,
                       input logic [15:0] a, input logic [15:0] w);
    if (m == 0) begin
      m0_req = r; m0_we = we; m0_addr = a; m0_wdata = w;
    end else begin
      m1_req = r; m1_we = we; m1_addr = a; m1_wdata = w;
    end
  endtask

  task automatic set_req(input int m, input logic r);
    if (m == 0) m0_req = r;
    else        m1_req = r;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_m(0, 1'b0, 1'b0, 16'h0, 16'h0);
    set_m(1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    tick();
    chk("rst_ctrl", {m1_ack, m0_ack, cs_vec, bus_we, bus_re}, 0);
    chk("rst_bus", {bus_addr, bus_wdata}, 0);
    chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
    last_rd[0] = 16'h0;
    last_rd[1] = 16'h0;
    rst = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    logic [15:0] exp_rd;
    int          m;
    m = int'(v.m);
    fixed_en = 1'b1;
    fixed_rdata = v.rdata;
    set_m(m, 1'b1, v.we, v.addr, v.wdata);
    exp_rd = v.we ? last_rd[m] : v.rdata;
    for (int k = 1; k <= v.width + 1; k++) begin
      tick();
      if (k <= v.width) begin
        chk("vec_cs", cs_vec, v.cs);
        chk("vec_strobe", {bus_we, bus_re}, {v.we, !v.we});
        chk("vec_addr", bus_addr, v.addr);
        chk("vec_wdata", bus_wdata, v.wdata);
        chk("vec_ack_early", {m1_ack, m0_ack}, 0);
      end else begin
        chk("vec_cs_done", {cs_vec, bus_we, bus_re}, 0);
        chk("vec_ack", {m1_ack, m0_ack}, v.m ? 2 : 1);
        chk("vec_rdata", v.m ? m1_rdata : m0_rdata, exp_rd);
        set_req(m, 1'b0);
      end
    end
    last_rd[m] = exp_rd;
    tick();
    chk("vec_idle", {m1_ack, m0_ack, cs_vec, bus_we, bus_re}, 0);
    fixed_en = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    logic [3:0]  exp_cs;
    logic [1:0]  exp_str;
    logic [1:0]  ack_seen;
    logic [15:0] exp_rd[2];
    logic [15:0] w_addr, w_wdata;
    logic        w_we;
    int          next_idle, acc_start, ack_at, win, ws, mlast, busy;

    fixed_en = 1'b0;
    fixed_rdata = 16'h0;
    rst = 1'b1;

    tbl[0] = '{1'b0, 1'b0, 16'h1234, 16'h0000, 16'hBEEF, 4'b0001, 1};
    tbl[1] = '{1'b1, 1'b1, 16'hC010, 16'hA5A5, 16'h0BAD, 4'b1000, 4};
    tbl[2] = '{1'b0, 1'b0, 16'h3FFF, 16'h7777, 16'h1111, 4'b0001, 1};
    tbl[3] = '{1'b1, 1'b0, 16'h4000, 16'h0101, 16'h2222, 4'b0010, 2};
    tbl[4] = '{1'b0, 1'b1, 16'hBFFF, 16'h3333, 16'hDEAD, 4'b0100, 3};
    tbl[5] = '{1'b1, 1'b0, 16'hC000, 16'h0202, 16'h4444, 4'b1000, 4};

    tie_cs  = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0100,
                4'b0100, 4'b0100, 4'b0000, 4'b0000};
    tie_ack = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00,
                2'b00, 2'b00, 2'b10, 2'b00};

    do_reset();
    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Simultaneous requests straight out of reset
    do_reset();
    set_m(0, 1'b1, 1'b0, 16'h4000, 16'h0);
    set_m(1, 1'b1, 1'b0, 16'h8000, 16'h0);
    for (int k = 1; k <= 9; k++) begin
      tick();
      chk("tie_cs", cs_vec, tie_cs[k-1]);
      chk("tie_ack", {m1_ack, m0_ack}, tie_ack[k-1]);
      if (k == 3) begin
        chk("tie_rd0", m0_rdata, mem_f(16'h4000));
        set_req(0, 1'b0);
      end
      if (k == 8) begin
        chk("tie_rd1", m1_rdata, mem_f(16'h8000));
        set_req(1, 1'b0);
      end
    end

    // Continuous requests from both masters must alternate
    do_reset();
    set_m(0, 1'b1, 1'b0, 16'h0100, 16'h0);
    set_m(1, 1'b1, 1'b0, 16'h0200, 16'h0);
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      tick();
      chk("alt_onehot", {31'd0, m0_ack & m1_ack}, 0);
      if (m0_ack || m1_ack) begin
        chk("alt_grant", {31'd0, m1_ack}, n % 2);
        n++;
        if (n == 6) begin
          set_req(0, 1'b0);
          set_req(1, 1'b0);
        end
      end
    end
    chk("alt_count", n, 6);
    tick();

    // Reset in the middle of a region-3 access
    do_reset();
    run_vec(tbl[0]);
    set_m(0, 1'b1, 1'b0, 16'hC000, 16'h0);
    tick();
    tick();
    chk("abort_pre_cs", cs_vec, 4'b1000);
    rst = 1'b1;
    set_req(0, 1'b0);
    tick();
    chk("abort_clear", {m1_ack, m0_ack, cs_vec, bus_we, bus_re}, 0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("abort_noack", {m1_ack, m0_ack, cs_vec}, 0);
    end
    set_m(0, 1'b1, 1'b0, 16'h0010, 16'h0);
    set_m(1, 1'b1, 1'b0, 16'h0020, 16'h0);
    tick();
    chk("abort_tie_cs", cs_vec, 4'b0001);
    tick();
    chk("abort_tie_ack", {m1_ack, m0_ack}, 2'b01);
    set_req(0, 1'b0);
    tick();
    tick();
    tick();
    chk("abort_m1_ack", {m1_ack, m0_ack}, 2'b10);
    set_req(1, 1'b0);
    tick();

    // Randomized traffic against a transaction-timing model
    do_reset();
    next_idle = cyc;
    busy = 0;
    mlast = 1;
    win = 0;
    ws = 0;
    acc_start = 0;
    ack_at = 0;
    w_addr = 16'h0;
    w_wdata = 16'h0;
    w_we = 1'b0;
    exp_rd[0] = 16'h0;
    exp_rd[1] = 16'h0;
    ack_seen = 2'b00;
    for (int it = 0; it < 600; it++) begin
      for (int m = 0; m < 2; m++) begin
        if (ack_seen[m] || ((m == 0 ? !m0_req : !m1_req)
                            && $urandom_range(0, 3) == 0)) begin
          if (ack_seen[m] && $urandom_range(0, 1) == 0)
            set_req(m, 1'b0);
          else
            set_m(m, 1'b1, 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom));
        end
      end
      if (cyc >= next_idle && (m0_req || m1_req)) begin
        if (m0_req && m1_req) win = 1 - mlast;
        else                  win = m1_req ? 1 : 0;
        w_addr  = win == 1 ? m1_addr  : m0_addr;
        w_wdata = win == 1 ? m1_wdata : m0_wdata;
        w_we    = win == 1 ? m1_we    : m0_we;
        ws = ws_of(w_addr[15:14]);
        acc_start = cyc;
        ack_at = cyc + ws + 2;
        next_idle = cyc + ws + 3;
        busy = 1;
      end
      tick();
      ack_seen = 2'b00;
      exp_cs = 4'b0000;
      exp_str = 2'b00;
      if (busy == 1 && cyc > acc_start && cyc <= acc_start + ws + 1) begin
        exp_cs = 4'b0001 << w_addr[15:14];
        exp_str = {w_we, !w_we};
      end
      if (busy == 1 && cyc == ack_at) begin
        ack_seen[win] = 1'b1;
        mlast = win;
        if (!w_we) exp_rd[win] = mem_f(w_addr);
      end
      chk("rnd_cs", cs_vec, exp_cs);
      chk("rnd_strobe", {bus_we, bus_re}, exp_str);
      chk("rnd_ack", {m1_ack, m0_ack}, ack_seen);
      chk("rnd_bus", {bus_addr, bus_wdata}, {w_addr, w_wdata});
      chk("rnd_rdata", {m1_rdata, m0_rdata}, {exp_rd[1], exp_rd[0]});
    end
    set_req(0, 1'b0);
    set_req(1, 1'b0);
    for (int k = 0; k < 20; k++) tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
